// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared defaults and scoreboard error-cause encoding
//   REG_AW_DEF / NUM_REGS_DEF : default register address width / register count
//   sb_err_e                  : per-entry error cause (none, overflow, underflow)
package hazard_scoreboard_pkg;
    localparam int REG_AW_DEF   = 4;
    localparam int NUM_REGS_DEF = 16;

    typedef enum logic [1:0] {
        SB_ERR_NONE = 2'd0,
        SB_ERR_OVF  = 2'd1,
        SB_ERR_UNF  = 2'd2
    } sb_err_e;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage / writeback / flush bundle for the hazard scoreboard
//   master : drives forward_en, id_*, wb_*, flush; observes hazard/busy/stall/error
//   slave  : the scoreboard side, the reverse directions
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEF,
    parameter int NUM_REGS    = NUM_REGS_DEF,
    parameter int STALL_CNT_W = 16
);
    logic                   forward_en;
    logic                   id_valid;
    logic [REG_AW-1:0]      id_src1;
    logic [REG_AW-1:0]      id_src2;
    logic                   id_two_src;
    logic                   id_wb_en;
    logic [REG_AW-1:0]      id_dest;
    logic                   id_mem_read;
    logic                   wb_valid;
    logic [REG_AW-1:0]      wb_dest;
    logic                   flush;
    logic                   hazard_detected;
    logic [NUM_REGS-1:0]    reg_busy;
    logic [STALL_CNT_W-1:0] stall_count;
    logic                   sb_error;

    modport master (
        output forward_en, id_valid, id_src1, id_src2, id_two_src, id_wb_en,
               id_dest, id_mem_read, wb_valid, wb_dest, flush,
        input  hazard_detected, reg_busy, stall_count, sb_error
    );

    modport slave (
        input  forward_en, id_valid, id_src1, id_src2, id_two_src, id_wb_en,
               id_dest, id_mem_read, wb_valid, wb_dest, flush,
        output hazard_detected, reg_busy, stall_count, sb_error
    );
endinterface

// File: rtl/hazard_sb_entry.sv
// hazard_sb_entry: one register's in-flight writer counter and load-latency timer
//   clk, rst_n : clock, async active-low reset
//   issue      : a writer to this register issues this cycle
//   is_load    : that writer is a load (arms the load timer)
//   wb         : a writer to this register retires this cycle
//   flush      : clear all state, ignoring issue/wb
//   busy       : writer counter is nonzero
//   ld_block   : load result not yet forwardable
//   err        : over/underflow attempted this cycle (counter held)
module hazard_sb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int PEND_W   = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    issue,
    input  logic    is_load,
    input  logic    wb,
    input  logic    flush,
    output logic    busy,
    output logic    ld_block,
    output sb_err_e err
);
    localparam int TW = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;

    logic [PEND_W-1:0] pend_q, pend_d;
    logic [TW-1:0]     ldt_q, ldt_d;

    always_comb begin
        err    = SB_ERR_NONE;
        pend_d = pend_q;
        // simultaneous issue and writeback cancel out
        if (flush)
            pend_d = '0;
        else if (issue && !wb) begin
            if (&pend_q) err = SB_ERR_OVF;
            else         pend_d = pend_q + 1'b1;
        end
        else if (wb && !issue) begin
            if (pend_q == '0) err = SB_ERR_UNF;
            else              pend_d = pend_q - 1'b1;
        end
        ldt_d = flush            ? '0 :
                issue            ? (is_load ? TW'(LOAD_LAT) : '0) :
                (ldt_q != '0)    ? ldt_q - 1'b1 : ldt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            ldt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            ldt_q  <= ldt_d;
        end
    end

    assign busy     = |pend_q;
    assign ld_block = |ldt_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register scoreboard hazard detection for the ID stage
//   clk, rst_n : clock, async active-low reset
//   sb (slave) : ID sources/dest, writeback, flush, forward_en in;
//                hazard_detected, reg_busy, stall_count, sb_error out
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS    = NUM_REGS_DEF,
    parameter int REG_AW      = REG_AW_DEF,
    parameter int PEND_W      = 2,
    parameter int LOAD_LAT    = 1,
    parameter int STALL_CNT_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    hazard_scoreboard_if.slave sb
);
    localparam int NA = 2 ** REG_AW;

    logic [NUM_REGS-1:0]    busy, ld_block;
    sb_err_e                err [NUM_REGS];
    logic [NA-1:0]          blk;
    logic                   hazard, issue, err_any;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   err_q, err_d;

    always_comb begin
        // addresses >= NUM_REGS land on the zero padding, so they never block
        blk                = '0;
        blk[NUM_REGS-1:0]  = sb.forward_en ? ld_block : busy;
        hazard  = sb.id_valid & (blk[sb.id_src1] | (sb.id_two_src & blk[sb.id_src2]));
        issue   = sb.id_valid & sb.id_wb_en & ~hazard & ~sb.flush;
        err_any = 1'b0;
        for (int r = 0; r < NUM_REGS; r++)
            err_any = err_any | (err[r] != SB_ERR_NONE);
        stall_d = (hazard & ~&stall_q) ? stall_q + 1'b1 : stall_q;
        err_d   = err_q | err_any;
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
        hazard_sb_entry #(
            .PEND_W   (PEND_W),
            .LOAD_LAT (LOAD_LAT)
        ) u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .issue    (issue & (sb.id_dest == REG_AW'(r))),
            .is_load  (sb.id_mem_read),
            .wb       (sb.wb_valid & (sb.wb_dest == REG_AW'(r))),
            .flush    (sb.flush),
            .busy     (busy[r]),
            .ld_block (ld_block[r]),
            .err      (err[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign sb.hazard_detected = hazard;
    assign sb.reg_busy        = busy;
    assign sb.stall_count     = stall_q;
    assign sb.sb_error        = err_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: scoreboard bench for hazard_scoreboard with a register-level reference model
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NR   = 12;
    localparam int AW   = 4;
    localparam int PW   = 2;
    localparam int LAT  = 1;
    localparam int SW   = 8;
    localparam int PMAX = (1 << PW) - 1;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(AW), .NUM_REGS(NR), .STALL_CNT_W(SW)) bus ();

    hazard_scoreboard #(
        .NUM_REGS(NR), .REG_AW(AW), .PEND_W(PW), .LOAD_LAT(LAT), .STALL_CNT_W(SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (bus)
    );

    typedef struct {
        bit            h;
        logic [NR-1:0] busy;
        int            stall;
        bit            err;
    } exp_t;

    exp_t q[$];
    int   pend [NR];
    int   ldt  [NR];
    int   m_stall;
    bit   m_err;
    int   n_checks = 0;
    int   n_fail   = 0;

    bit         fwd, v, two, we, mem, wbv, fl;
    logic [3:0] s1, s2, d, wd;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit blocked(input logic [3:0] r);
        if (r >= NR) return 1'b0;
        return fwd ? (ldt[r] > 0) : (pend[r] > 0);
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NR; r++) begin
            pend[r] = 0;
            ldt[r]  = 0;
        end
    endtask

    task automatic idle();
        v = 0; we = 0; mem = 0; wbv = 0; fl = 0; two = 0;
    endtask

    // one clock: apply stimulus, predict this cycle's outputs, advance the model
    task automatic step();
        bit            h, iss;
        logic [NR-1:0] b;
        sb_err_e       cause;
        @(posedge clk);
        #1;
        bus.forward_en = fwd;  bus.id_valid = v;    bus.id_src1 = s1;
        bus.id_src2 = s2;      bus.id_two_src = two; bus.id_wb_en = we;
        bus.id_dest = d;       bus.id_mem_read = mem; bus.wb_valid = wbv;
        bus.wb_dest = wd;      bus.flush = fl;
        #1;
        h = v && (blocked(s1) || (two && blocked(s2)));
        for (int r = 0; r < NR; r++) b[r] = pend[r] > 0;
        q.push_back('{h, b, m_stall, m_err});
        if (h) m_stall = (m_stall < SMAX) ? m_stall + 1 : SMAX;
        if (fl) model_clear();
        else begin
            iss = v && we && !h;
            for (int r = 0; r < NR; r++) begin
                bit inc, dec;
                inc   = iss && (d == r);
                dec   = wbv && (wd == r);
                cause = SB_ERR_NONE;
                if (inc && !dec) begin
                    if (pend[r] == PMAX) cause = SB_ERR_OVF;
                    else pend[r]++;
                end else if (dec && !inc) begin
                    if (pend[r] == 0) cause = SB_ERR_UNF;
                    else pend[r]--;
                end
                if (cause != SB_ERR_NONE) m_err = 1'b1;
                if (inc) ldt[r] = mem ? LAT : 0;
                else if (ldt[r] > 0) ldt[r]--;
            end
        end
    endtask

    // reset asserted between edges: outputs must clear without waiting for a clock
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_hazard", bus.hazard_detected, 0);
        chk("rst_busy", bus.reg_busy, 0);
        chk("rst_stall", bus.stall_count, 0);
        chk("rst_err", bus.sb_error, 0);
        model_clear();
        m_stall = 0;
        m_err   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("hazard", bus.hazard_detected, e.h);
                chk("reg_busy", bus.reg_busy, e.busy);
                chk("stall_count", bus.stall_count, e.stall);
                chk("sb_error", bus.sb_error, e.err);
            end
        end
    end

    initial begin
        bus.forward_en = 0; bus.id_valid = 0; bus.id_src1 = 0; bus.id_src2 = 0;
        bus.id_two_src = 0; bus.id_wb_en = 0; bus.id_dest = 0; bus.id_mem_read = 0;
        bus.wb_valid = 0;   bus.wb_dest = 0;  bus.flush = 0;
        fwd = 0; s1 = 0; s2 = 0; d = 0; wd = 0;
        idle();
        do_reset();

        // non-forwarding: R1 writer, dependent stalls until the cycle after wb
        fwd = 0; v = 1; we = 1; d = 1; s1 = 0; step();
        we = 0; s1 = 1; step(); chk("nf_stall_first", bus.hazard_detected, 1);
        step(); step();
        wbv = 1; wd = 1; step(); chk("nf_stall_at_wb", bus.hazard_detected, 1);
        wbv = 0; step();
        chk("nf_clear", bus.hazard_detected, 0);
        chk("nf_stall_cnt", bus.stall_count, 4);

        // forwarding load-use: exactly LAT stall cycles
        do_reset();
        fwd = 1; idle(); v = 1; we = 1; d = 2; mem = 1; s1 = 0; step();
        mem = 0; s1 = 2; d = 3; step(); chk("lu_stall", bus.hazard_detected, 1);
        step(); chk("lu_go", bus.hazard_detected, 0);
        idle(); step(); chk("lu_stall_cnt", bus.stall_count, LAT);

        // forwarding non-load producer: no stall
        do_reset();
        fwd = 1; idle(); v = 1; we = 1; d = 2; s1 = 0; step();
        s1 = 2; d = 3; step(); chk("alu_nostall", bus.hazard_detected, 0);
        idle(); step(); chk("alu_stall_cnt", bus.stall_count, 0);

        // same-cycle issue and writeback on R5
        do_reset();
        fwd = 0; idle(); v = 1; we = 1; d = 5; s1 = 0; step();
        wbv = 1; wd = 5; step();
        idle(); step(); chk("r5_busy", bus.reg_busy[5], 1);
        wbv = 1; wd = 5; step();
        idle(); step(); chk("r5_free", bus.reg_busy[5], 0);
        chk("r5_err", bus.sb_error, 0);

        // flush clears two writers; later wb underflows, error is sticky
        do_reset();
        idle(); v = 1; we = 1; d = 4; s1 = 0; step(); step();
        fl = 1; step();
        idle(); step(); chk("flush_busy", bus.reg_busy, 0);
        wbv = 1; wd = 4; step();
        idle(); step(); chk("unf_err", bus.sb_error, 1);
        step(); step(); chk("unf_sticky", bus.sb_error, 1);

        // second source only matters when read
        do_reset();
        fwd = 0; idle(); v = 1; we = 1; d = 6; s1 = 0; step();
        we = 0; s2 = 6; two = 0; step(); chk("src2_unread", bus.hazard_detected, 0);
        two = 1; step(); chk("src2_read", bus.hazard_detected, 1);

        // overflow of the writer counter
        do_reset();
        idle(); v = 1; we = 1; d = 7; s1 = 0; two = 0;
        repeat (PMAX) step();
        chk("ovf_pre", bus.sb_error, 0);
        step();
        idle(); step(); chk("ovf_err", bus.sb_error, 1);
        chk("ovf_busy", bus.reg_busy[7], 1);

        // destination beyond NUM_REGS is never tracked
        do_reset();
        fwd = 0; idle(); v = 1; we = 1; d = 13; s1 = 0; step();
        we = 0; s1 = 13; step();
        chk("untracked_busy", bus.reg_busy, 0);
        chk("untracked_hazard", bus.hazard_detected, 0);

        // stall counter saturates
        do_reset();
        fwd = 0; idle(); v = 1; we = 1; d = 1; s1 = 0; step();
        we = 0; s1 = 1; repeat (SMAX + 45) step();
        chk("stall_sat", bus.stall_count, SMAX);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) fwd = $urandom_range(0, 1);
            v   = $urandom_range(0, 9) < 8;
            s1  = 4'($urandom_range(0, 15));
            s2  = 4'($urandom_range(0, 15));
            two = $urandom_range(0, 1);
            d   = 4'($urandom_range(0, 15));
            we  = ($urandom_range(0, 9) < 6) && (d >= NR || pend[d] < PMAX);
            mem = $urandom_range(0, 9) < 3;
            wd  = 4'($urandom_range(0, 15));
            wbv = ($urandom_range(0, 9) < 4) && (wd < NR) && (pend[wd] > 0);
            fl  = $urandom_range(0, 49) == 0;
            step();
        end

        // reset mid-operation with pending[3] = 2 and a stalled dependent in ID
        do_reset();
        fwd = 0; idle(); v = 1; we = 1; d = 3; s1 = 0; step(); step();
        we = 0; s1 = 3; step(); step();
        do_reset();

        idle(); step(); step();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left unchecked", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised, clocked hazard detection for the ID stage. It replaces purely comparator-based detection with a per-register scoreboard that tracks in-flight writers and multi-cycle load latency. It sits beside the ID/EXE pipeline register and drives the ID/IF stall. It supports forwarding and non-forwarding modes, and counts stall cycles for performance analysis.

## Interface

Parameters:
- NUM_REGS, 16, architectural registers tracked
- REG_AW, 4, register address width (2**REG_AW >= NUM_REGS)
- PEND_W, 2, width of per-register in-flight writer counter
- LOAD_LAT, 1, cycles after issue during which a load result is not forwardable
- STALL_CNT_W, 16, width of stall performance counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- forward_en  in  1  1 = forwarding mode, 0 = stall on any pending writer
- id_valid  in  1  ID stage holds a real instruction
- id_src1  in  REG_AW  first source register
- id_src2  in  REG_AW  second source register
- id_two_src  in  1  id_src2 is read
- id_wb_en  in  1  ID instruction writes a register
- id_dest  in  REG_AW  ID instruction destination
- id_mem_read  in  1  ID instruction is a load
- wb_valid  in  1  a writer retires this cycle
- wb_dest  in  REG_AW  retiring destination
- flush  in  1  kill all in-flight writers (branch taken)
- hazard_detected  out  1  stall IF/ID, bubble ID/EXE
- reg_busy  out  NUM_REGS  bit r = pending[r] != 0
- stall_count  out  STALL_CNT_W  saturating count of stall cycles
- sb_error  out  1  sticky scoreboard over/underflow flag

## Operation

- State per register r: pending[r] (PEND_W bits) and ld_timer[r] (clog2(LOAD_LAT+1) bits).
- src_hit(s) = (s < NUM_REGS) and the source is read (src1 always, src2 only if id_two_src).
- Non-forwarding: hazard if id_valid and any read source has pending != 0.
- Forwarding: hazard if id_valid and any read source has ld_timer != 0.
- hazard_detected is combinational from registered state and current ID inputs.
- issue = id_valid & id_wb_en & ~hazard_detected & ~flush.
- On issue: pending[id_dest] increments and ld_timer[id_dest] loads LOAD_LAT if id_mem_read, else 0.
- On wb_valid: pending[wb_dest] decrements.
- If issue and wb_valid hit the same register in the same cycle, pending is unchanged.
- Every nonzero ld_timer not being reloaded decrements by 1 each cycle.
- Overflow (increment at all-ones) or underflow (decrement at 0): the counter holds its value and sb_error sets; sb_error clears only on reset.
- flush: all pending and ld_timer clear next cycle; any issue or wb that cycle is ignored. Upstream guarantees no later writebacks for flushed writers.
- stall_count increments on every cycle with hazard_detected = 1 and saturates at all-ones.
- A destination >= NUM_REGS is never tracked.

## Timing

- Reset (async assert, sync release by upstream): pending = 0, ld_timer = 0, hazard_detected = 0, reg_busy = 0, stall_count = 0, sb_error = 0.
- Issue in cycle t becomes visible to hazard_detected and reg_busy in cycle t+1.
- Load-use in forwarding mode with LOAD_LAT = L: a dependent in ID at t+1 stalls exactly L cycles.
- Writeback at cycle t clears the hazard in cycle t+1; no same-cycle bypass.
- hazard_detected has zero latency from the ID inputs.

## Structure

- A shared package holds the REG_AW default, the NUM_REGS default, and the sb_error cause encoding used by the bench.
- The natural sub-module is hazard_sb_entry: one register's pending counter and load timer. It has issue/wb/flush inputs and busy/ld_block outputs, and is instantiated NUM_REGS times via generate.
- The top level holds the source decode, hazard OR-reduction, stall counter and error flag.

## Test plan

- Reset mid-operation: with pending[3] = 2, assert rst_n = 0 -> all outputs 0 immediately.
- forward_en = 0: issue R1 writer at t, id_src1 = 1 at t+1 -> hazard = 1 until the cycle after wb_dest = 1; stall_count = number of stall cycles.
- forward_en = 1, LOAD_LAT = 1: load to R2, then ADD reading R2 -> exactly 1 stall cycle. Same sequence with a non-load writer -> 0 stalls.
- Issue of R5 and writeback of R5 in the same cycle with pending[5] = 1 -> pending stays 1 and reg_busy[5] = 1.
- Two writers to R4, then flush -> reg_busy = 0 next cycle. A following wb on R4 -> sb_error = 1 (underflow) and stays set.
- id_two_src = 0 with id_src2 = busy register -> no hazard. id_two_src = 1 -> hazard. stall_count driven past 2**STALL_CNT_W - 1 -> holds all-ones.
